// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: leaky membrane integration, threshold spike,
// refractory hold-off and a saturating spike counter. All outputs are registered.
module lif_neuron #(
    parameter int WIDTH         = 8,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRAC_CYCLES = 4,
    parameter int RESET_POT     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             syn_valid,
    input  logic [WIDTH-1:0] exc_in,
    input  logic [WIDTH-1:0] inh_in,
    input  logic [WIDTH-1:0] threshold,
    output logic             spike,
    output logic             refractory,
    output logic [WIDTH-1:0] membrane,
    output logic [7:0]       spike_count
);

    // state         | meaning
    // ST_INTEGRATE  | membrane leaks and integrates synaptic current, may fire
    // ST_REFRACTORY | membrane pinned at RESET_POT, inputs ignored, counting down
    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } state_t;

    localparam int               VW          = WIDTH + 2;
    localparam logic [WIDTH-1:0] RST_POT     = WIDTH'(RESET_POT);
    localparam logic [7:0]       REFRAC_INIT = 8'(REFRAC_CYCLES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q, mem_d;
    logic             spike_q, spike_d;
    logic             refr_q, refr_d;
    logic [7:0]       rcnt_q, rcnt_d;
    logic [7:0]       scnt_q, scnt_d;

    logic signed [VW-1:0] v_cur, v_leak, v_exc, v_inh, v_sum;
    logic [WIDTH-1:0]     v_sat;
    logic                 fire;

    // Two guard bits make the sum exact: range is [-(2^W-1), 2^(W+1)-2].
    always_comb begin
        v_cur  = signed'({2'b00, mem_q});
        v_leak = signed'({2'b00, (mem_q >> LEAK_SHIFT)});
        v_exc  = syn_valid ? signed'({2'b00, exc_in}) : '0;
        v_inh  = syn_valid ? signed'({2'b00, inh_in}) : '0;
        v_sum  = v_cur - v_leak + v_exc - v_inh;
        if (v_sum < 0) begin
            v_sat = '0;
        end else if (v_sum > signed'({2'b00, {WIDTH{1'b1}}})) begin
            v_sat = '1;
        end else begin
            v_sat = v_sum[WIDTH-1:0];
        end
        fire = (threshold != '0) && (v_sat >= threshold);
    end

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        spike_d = 1'b0;
        refr_d  = refr_q;
        rcnt_d  = rcnt_q;
        scnt_d  = scnt_q;
        if (ena) begin
            case (state_q)
                ST_INTEGRATE: begin
                    if (fire) begin
                        spike_d = 1'b1;
                        mem_d   = RST_POT;
                        scnt_d  = (scnt_q == 8'hFF) ? 8'hFF : scnt_q + 8'd1;
                        if (REFRAC_CYCLES > 0) begin
                            state_d = ST_REFRACTORY;
                            rcnt_d  = REFRAC_INIT;
                            refr_d  = 1'b1;
                        end
                    end else begin
                        mem_d = v_sat;
                    end
                end
                ST_REFRACTORY: begin
                    mem_d = RST_POT;
                    if (rcnt_q <= 8'd1) begin
                        state_d = ST_INTEGRATE;
                        refr_d  = 1'b0;
                        rcnt_d  = 8'd0;
                    end else begin
                        rcnt_d = rcnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_INTEGRATE;
                    refr_d  = 1'b0;
                    rcnt_d  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INTEGRATE;
            mem_q   <= '0;
            spike_q <= 1'b0;
            refr_q  <= 1'b0;
            rcnt_q  <= 8'd0;
            scnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            spike_q <= spike_d;
            refr_q  <= refr_d;
            rcnt_q  <= rcnt_d;
            scnt_q  <= scnt_d;
        end
    end

    assign spike       = spike_q;
    assign refractory  = refr_q;
    assign membrane    = mem_q;
    assign spike_count = scnt_q;

endmodule
